// File: rtl/sram_dp_arbiter.sv
// Purpose: shares the two ports of a dual-port tile SRAM among N_REQ requesters,
//          granting up to two requests per cycle with round-robin fairness.
// Latency: SRAM pins show the command one cycle after the handshake; read data
//          returns on rsp_valid/rsp_rdata two cycles after the handshake.
// Backpressure: req_ready is the only backpressure. Responses cannot be stalled.
//
// Ports: clk/rst_n (async active-low); req_valid/req_we/req_addr/req_wdata/req_ready
//        request side; rsp_valid/rsp_rdata response side; sram_* are the macro pins
//        for port 1 and port 2 (CE1/CE2 are tied to clk outside this block).
// Build option: define SRAM_ARB_FIXED_PRIO_EN for fixed priority (lowest index
//        wins). Leave it undefined for round-robin.
module sram_dp_arbiter #(
  parameter int N_REQ = 3,
  parameter int AW    = 7,
  parameter int DW    = 512
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ-1:0]    req_we,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*DW-1:0] req_wdata,
  output logic [N_REQ-1:0]    req_ready,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [N_REQ*DW-1:0] rsp_rdata,
  output logic                sram_csb1,
  output logic                sram_csb2,
  output logic                sram_web1,
  output logic                sram_web2,
  output logic                sram_oeb1,
  output logic                sram_oeb2,
  output logic [AW-1:0]       sram_a1,
  output logic [AW-1:0]       sram_a2,
  output logic [DW-1:0]       sram_i1,
  output logic [DW-1:0]       sram_i2,
  input  logic [DW-1:0]       sram_o1,
  input  logic [DW-1:0]       sram_o2
);
  localparam int IW = (N_REQ > 2) ? $clog2(N_REQ) : 1;
  typedef logic [IW-1:0] idx_t;

  logic          a_vld, b_vld, a_gnt, b_gnt;
  idx_t          a_idx, b_idx;
  logic [AW-1:0] a_addr, b_addr;
  logic          a_we, b_we;
  logic [DW-1:0] a_wdata, b_wdata;

  logic          csb1_q, csb2_q, web1_q, web2_q;
  logic [AW-1:0] a1_q, a2_q;
  logic [DW-1:0] i1_q, i2_q;

  // Owner pipelines {valid, requester index}, two stages per port.
  logic          s1_vld1_q, s2_vld1_q, s1_vld2_q, s2_vld2_q;
  idx_t          s1_own1_q, s2_own1_q, s1_own2_q, s2_own2_q;

`ifndef SRAM_ARB_FIXED_PRIO_EN
  idx_t          p_q, p_d;
`endif

  // Scan requesters from the pointer (or from 0 in fixed-priority builds) and
  // pick the first two valid ones.
  always_comb begin : scan
    int   pos;
    idx_t idx;
    a_vld = 1'b0;
    b_vld = 1'b0;
    a_idx = '0;
    b_idx = '0;
    pos   = 0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
      pos = k;
`else
      pos = int'(p_q) + k;
      if (pos >= N_REQ) pos = pos - N_REQ;
`endif
      idx = idx_t'(pos);
      if (req_valid[idx]) begin
        if (!a_vld) begin
          a_vld = 1'b1;
          a_idx = idx;
        end else if (!b_vld) begin
          b_vld = 1'b1;
          b_idx = idx;
        end
      end
    end
  end

  assign a_addr  = req_addr[a_idx*AW +: AW];
  assign b_addr  = req_addr[b_idx*AW +: AW];
  assign a_we    = req_we[a_idx];
  assign b_we    = req_we[b_idx];
  assign a_wdata = req_wdata[a_idx*DW +: DW];
  assign b_wdata = req_wdata[b_idx*DW +: DW];

  // B yields when it targets A's address and either side writes. Two reads
  // of the same word are harmless and both proceed. Nothing is granted in reset.
  assign a_gnt = rst_n & a_vld;
  assign b_gnt = rst_n & b_vld & ~((a_addr == b_addr) & (a_we | b_we));

  always_comb begin
    req_ready = '0;
    if (a_gnt) req_ready[a_idx] = 1'b1;
    if (b_gnt) req_ready[b_idx] = 1'b1;
  end

`ifndef SRAM_ARB_FIXED_PRIO_EN
  always_comb begin : ptr
    idx_t last;
    last = b_gnt ? b_idx : a_idx;
    p_d  = p_q;
    if (a_gnt) p_d = (int'(last) == N_REQ - 1) ? '0 : last + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) p_q <= '0;
    else        p_q <= p_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csb1_q    <= 1'b1;
      csb2_q    <= 1'b1;
      web1_q    <= 1'b1;
      web2_q    <= 1'b1;
      a1_q      <= '0;
      a2_q      <= '0;
      i1_q      <= '0;
      i2_q      <= '0;
      s1_vld1_q <= 1'b0;
      s2_vld1_q <= 1'b0;
      s1_vld2_q <= 1'b0;
      s2_vld2_q <= 1'b0;
      s1_own1_q <= '0;
      s2_own1_q <= '0;
      s1_own2_q <= '0;
      s2_own2_q <= '0;
    end else begin
      // An idle port deselects and parks in read mode. Address and data hold.
      csb1_q <= ~a_gnt;
      web1_q <= ~(a_gnt & a_we);
      if (a_gnt) begin
        a1_q <= a_addr;
        i1_q <= a_wdata;
      end
      csb2_q <= ~b_gnt;
      web2_q <= ~(b_gnt & b_we);
      if (b_gnt) begin
        a2_q <= b_addr;
        i2_q <= b_wdata;
      end
      s1_vld1_q <= a_gnt & ~a_we;
      s1_own1_q <= a_idx;
      s2_vld1_q <= s1_vld1_q;
      s2_own1_q <= s1_own1_q;
      s1_vld2_q <= b_gnt & ~b_we;
      s1_own2_q <= b_idx;
      s2_vld2_q <= s1_vld2_q;
      s2_own2_q <= s1_own2_q;
    end
  end

  assign sram_csb1 = csb1_q;
  assign sram_csb2 = csb2_q;
  assign sram_web1 = web1_q;
  assign sram_web2 = web2_q;
  assign sram_oeb1 = 1'b0;
  assign sram_oeb2 = 1'b0;
  assign sram_a1   = a1_q;
  assign sram_a2   = a2_q;
  assign sram_i1   = i1_q;
  assign sram_i2   = i2_q;

  // Port 2 is applied first, so port 1 overrides it if both name one owner.
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    if (s2_vld2_q) begin
      rsp_valid[s2_own2_q]            = 1'b1;
      rsp_rdata[s2_own2_q*DW +: DW]   = sram_o2;
    end
    if (s2_vld1_q) begin
      rsp_valid[s2_own1_q]            = 1'b1;
      rsp_rdata[s2_own1_q*DW +: DW]   = sram_o1;
    end
  end

endmodule

// File: tb/tb_sram_dp_arbiter.sv
// Purpose: directed self-checking bench for sram_dp_arbiter with a behavioural
//          dual-port SRAM model attached to the pins.
// Timing: inputs are driven 1 time unit after posedge, and outputs are sampled 1 unit later.
module tb_sram_dp_arbiter;
  localparam int N  = 3;
  localparam int AW = 7;
  localparam int DW = 512;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_we, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata, rsp_rdata;
  logic            sram_csb1, sram_csb2, sram_web1, sram_web2, sram_oeb1, sram_oeb2;
  logic [AW-1:0]   sram_a1, sram_a2;
  logic [DW-1:0]   sram_i1, sram_i2, sram_o1, sram_o2;

  int n_chk = 0;
  int n_err = 0;
  int gcnt [N];
  logic [N-1:0] exp_rdy [6];

  always #5 clk = ~clk;

  sram_dp_arbiter #(.N_REQ(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .sram_csb1(sram_csb1), .sram_csb2(sram_csb2),
    .sram_web1(sram_web1), .sram_web2(sram_web2),
    .sram_oeb1(sram_oeb1), .sram_oeb2(sram_oeb2),
    .sram_a1(sram_a1), .sram_a2(sram_a2),
    .sram_i1(sram_i1), .sram_i2(sram_i2),
    .sram_o1(sram_o1), .sram_o2(sram_o2)
  );

  // Behavioural SRAM: unwritten words read back a byte pattern of their address.
  logic [DW-1:0] mem [128];
  logic [127:0]  wr_mask = '0;

  function automatic logic [DW-1:0] pat(input logic [7:0] a);
    return {64{a}};
  endfunction

  function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
    return wr_mask[a] ? mem[a] : pat({1'b0, a});
  endfunction

  always @(posedge clk) begin
    if (!sram_csb1) begin
      if (!sram_web1) begin
        mem[sram_a1]     <= sram_i1;
        wr_mask[sram_a1] <= 1'b1;
      end else begin
        sram_o1 <= rd(sram_a1);
      end
    end
    if (!sram_csb2) begin
      if (!sram_web2) begin
        mem[sram_a2]     <= sram_i2;
        wr_mask[sram_a2] <= 1'b1;
      end else begin
        sram_o2 <= rd(sram_a2);
      end
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]           = v;
    req_we[i]              = we;
    req_addr[i*AW +: AW]   = a;
    req_wdata[i*DW +: DW]  = d;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    sram_o1   = '0;
    sram_o2   = '0;
    for (int i = 0; i < N; i++) gcnt[i] = 0;
`ifdef SRAM_ARB_FIXED_PRIO_EN
    for (int k = 0; k < 6; k++) exp_rdy[k] = 3'b011;
`else
    exp_rdy[0] = 3'b011; exp_rdy[1] = 3'b101; exp_rdy[2] = 3'b110;
    exp_rdy[3] = 3'b011; exp_rdy[4] = 3'b101; exp_rdy[5] = 3'b110;
`endif

    // Reset state. Requests are held valid to confirm that nothing is granted.
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 7'h05, '0);
    #1;
    chk("rst_ready", req_ready, 3'b000);
    chk("rst_ctl", {sram_csb1, sram_csb2, sram_web1, sram_web2, sram_oeb1, sram_oeb2}, 6'b111100);
    chk("rst_addr", {sram_a1, sram_a2}, 14'h0);
    chk("rst_wdata1", sram_i1, '0);
    chk("rst_wdata2", sram_i2, '0);
    chk("rst_rsp", rsp_valid, 3'b000);
    req_valid = '0;
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Single write then read by req0.
    set_req(0, 1'b1, 1'b1, 7'h05, pat(8'hA5));
    #1 chk("wr_ready", req_ready, 3'b001);
    tick();
    chk("wr_pins", {sram_csb1, sram_web1, sram_csb2}, 3'b001);
    chk("wr_a1", sram_a1, 7'h05);
    chk("wr_i1", sram_i1, pat(8'hA5));
    set_req(0, 1'b1, 1'b0, 7'h05, '0);
    #1 chk("rd_ready", req_ready, 3'b001);
    tick();
    req_valid = '0;
    chk("rd_pins", {sram_csb1, sram_web1}, 2'b01);
    chk("rd_rsp_early", rsp_valid, 3'b000);
    tick();
    chk("rd_rsp", rsp_valid, 3'b001);
    chk("rd_data", rsp_rdata[0 +: DW], pat(8'hA5));
    chk("rd_idle_csb", {sram_csb1, sram_csb2}, 2'b11);
    tick();
    chk("rd_rsp_once", rsp_valid, 3'b000);

    // Pointer wrap: req2 alone, then req0 and req2 together.
    set_req(2, 1'b1, 1'b0, 7'h07, '0);
    #1 chk("wrap_ready0", req_ready, 3'b100);
    tick();
    chk("wrap_a1", sram_a1, 7'h07);
    chk("wrap_csb0", {sram_csb1, sram_csb2}, 2'b01);
    set_req(0, 1'b1, 1'b0, 7'h08, '0);
    set_req(2, 1'b1, 1'b0, 7'h09, '0);
    #1 chk("wrap_ready1", req_ready, 3'b101);
    tick();
    req_valid = '0;
    chk("wrap_ports", {sram_a1, sram_a2}, {7'h08, 7'h09});
    chk("wrap_csb1", {sram_csb1, sram_csb2}, 2'b00);
    chk("wrap_rsp0", rsp_valid, 3'b100);
    chk("wrap_data0", rsp_rdata[2*DW +: DW], pat(8'h07));
    tick();
    chk("wrap_rsp1", rsp_valid, 3'b101);
    chk("wrap_data1_r0", rsp_rdata[0 +: DW], pat(8'h08));
    chk("wrap_data1_r2", rsp_rdata[2*DW +: DW], pat(8'h09));

    // Dual grant: req0 and req1 both read.
    tick();
    set_req(0, 1'b1, 1'b0, 7'h10, '0);
    set_req(1, 1'b1, 1'b0, 7'h20, '0);
    #1 chk("dual_ready", req_ready, 3'b011);
    tick();
    req_valid = '0;
    chk("dual_ports", {sram_a1, sram_a2}, {7'h10, 7'h20});
    chk("dual_csb", {sram_csb1, sram_csb2, sram_web1, sram_web2}, 4'b0011);
    tick();
    chk("dual_rsp", rsp_valid, 3'b011);
    chk("dual_data0", rsp_rdata[0 +: DW], pat(8'h10));
    chk("dual_data1", rsp_rdata[DW +: DW], pat(8'h20));
    tick();
    chk("dual_rsp_end", rsp_valid, 3'b000);

    // Collision: req0 writes 0x33 while req1 reads 0x33.
    set_req(0, 1'b1, 1'b1, 7'h33, pat(8'h3C));
    set_req(1, 1'b1, 1'b0, 7'h33, '0);
    #1 chk("coll_ready0", req_ready, 3'b001);
    tick();
    req_valid[0] = 1'b0;
    #1 chk("coll_ready1", req_ready, 3'b010);
    chk("coll_pins", {sram_csb1, sram_web1, sram_csb2}, 3'b001);
    tick();
    req_valid = '0;
    chk("coll_a1", sram_a1, 7'h33);
    chk("coll_rd_pins", {sram_csb1, sram_web1}, 2'b01);
    tick();
    chk("coll_rsp", rsp_valid, 3'b010);
    chk("coll_data", rsp_rdata[DW +: DW], pat(8'h3C));

    // Fairness: a lone req2 resets the pointer, then all three contend for six cycles.
    tick();
    set_req(2, 1'b1, 1'b0, 7'h01, '0);
    #1 chk("fair_pre", req_ready, 3'b100);
    tick();
    for (int k = 0; k < 8; k++) begin
      if (k < 6) begin
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 7'(7'h40 + i), '0);
      end else begin
        req_valid = '0;
      end
      #1;
      if (k < 6) begin
        chk($sformatf("fair_ready_%0d", k), req_ready, exp_rdy[k]);
        for (int i = 0; i < N; i++) gcnt[i] += int'(req_ready[i]);
      end
      if (k == 0)      chk("fair_rsp_0", rsp_valid, 3'b000);
      else if (k == 1) chk("fair_rsp_1", rsp_valid, 3'b100);
      else             chk($sformatf("fair_rsp_%0d", k), rsp_valid, exp_rdy[k-2]);
      tick();
    end
`ifdef SRAM_ARB_FIXED_PRIO_EN
    chk("fair_cnt0", gcnt[0], 6);
    chk("fair_cnt1", gcnt[1], 6);
    chk("fair_cnt2", gcnt[2], 0);
`else
    chk("fair_cnt0", gcnt[0], 4);
    chk("fair_cnt1", gcnt[1], 4);
    chk("fair_cnt2", gcnt[2], 4);
`endif

    // Reset while a read is in flight.
    set_req(0, 1'b1, 1'b0, 7'h05, '0);
    #1 chk("mrst_ready", req_ready, 3'b001);
    tick();
    chk("mrst_csb_pre", sram_csb1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mrst_csb", {sram_csb1, sram_csb2}, 2'b11);
    chk("mrst_ready_low", req_ready, 3'b000);
    tick();
    chk("mrst_rsp", rsp_valid, 3'b000);
    chk("mrst_csb_hold", {sram_csb1, sram_csb2}, 2'b11);
    req_valid = '0;
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("mrst_rsp_after", rsp_valid, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
